// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK joystick SPI link: frame geometry,
// LED command prefix, responder state encoding and the TX frame builder.
package jstk_pkg;

  localparam int JSTK_FRAME_BYTES = 5;
  localparam int JSTK_FRAME_BITS  = 40;
  localparam logic [5:0] JSTK_LED_CMD_PREFIX = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CLOSE = 2'd3
  } jstk_resp_state_e;

  // Byte 0 lands in bits [39:32] so the frame shifts out MSB first from bit 39.
  function automatic logic [39:0] jstk_build_frame(input logic [9:0] x,
                                                   input logic [9:0] y,
                                                   input logic [2:0] btn);
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-bit flop synchronizer with registered rise/fall strobes on each
// synchronized bit; strobes appear DEPTH+1 cycles after a pin transition.
module spi_input_sync #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stages [DEPTH];
  logic [WIDTH-1:0] prev;

  // Reset clears every stage so a pin already low never produces a stale fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
      prev <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      stages[0] <= async_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      prev <= stages[DEPTH-1];
      rise <= stages[DEPTH-1] & ~prev;
      fall <= ~stages[DEPTH-1] & prev;
    end
  end

  assign sync_out = stages[DEPTH-1];

endmodule

// File: rtl/spi_joystick_responder.sv
// PmodJSTK SPI slave model: shifts out a 5-byte position/button frame and,
// when JSTK_RESP_LED_CMD_EN is defined, decodes the first MOSI byte as an LED command.
module spi_joystick_responder
  import jstk_pkg::*;
#(
  parameter int POS_W     = 10,
  parameter int SCLK_SYNC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [POS_W-1:0] x_pos,
  input  logic [POS_W-1:0] y_pos,
  input  logic [2:0]       buttons,
  output logic [1:0]       led_out,
  output logic             xfer_done,
  output logic             frame_err
);

  logic [2:0] sync_lvl, sync_rise, sync_fall;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  spi_input_sync #(.WIDTH(3), .DEPTH(SCLK_SYNC)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in ({sclk, ss, mosi}),
    .sync_out (sync_lvl),
    .rise     (sync_rise),
    .fall     (sync_fall)
  );

  assign sclk_rise = sync_rise[2];
  assign sclk_fall = sync_fall[2];
  assign ss_rise   = sync_rise[1];
  assign ss_fall   = sync_fall[1];

  jstk_resp_state_e state;
  logic [39:0] tx_frame, tx_sr;
  logic [2:0]  bit_idx, byte_cnt;
  logic        close_any, frame_full;

  assign tx_frame   = jstk_build_frame(10'(x_pos), 10'(y_pos), buttons);
  assign close_any  = ss_rise && (state == ST_LOAD || state == ST_SHIFT);
  assign frame_full = ({byte_cnt, bit_idx} == 6'(JSTK_FRAME_BITS));

  // The zero-filled shift register naturally drives 0 once all 40 bits are out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      miso      <= 1'b0;
      tx_sr     <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      xfer_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      xfer_done <= close_any && frame_full;
      frame_err <= close_any && !frame_full;
      case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (ss_fall) begin
            tx_sr    <= tx_frame;
            miso     <= tx_frame[39];
            bit_idx  <= '0;
            byte_cnt <= '0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (ss_rise) begin
            miso  <= 1'b0;
            state <= ST_CLOSE;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            miso  <= 1'b0;
            state <= ST_CLOSE;
          end else begin
            if (sclk_rise) begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7 && byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
            end
            if (sclk_fall) begin
              tx_sr <= {tx_sr[38:0], 1'b0};
              miso  <= tx_sr[38];
            end
          end
        end
        ST_CLOSE: begin
          miso  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JSTK_RESP_LED_CMD_EN
  logic       mosi_s;
  logic [7:0] rx_byte;
  logic [1:0] led_q;
  logic       unused_bits;

  assign mosi_s      = sync_lvl[0];
  assign led_out     = led_q;
  assign unused_bits = ^{sync_lvl[2:1], sync_rise[0], sync_fall[0]};

  // Only the first byte is captured; later bytes leave rx_byte untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte <= '0;
      led_q   <= '0;
    end else begin
      if (state == ST_IDLE && ss_fall)
        rx_byte <= '0;
      else if (state == ST_SHIFT && !ss_rise && sclk_rise && byte_cnt == 3'd0)
        rx_byte <= {rx_byte[6:0], mosi_s};
      if (close_any && frame_full && rx_byte[7:2] == JSTK_LED_CMD_PREFIX)
        led_q <= rx_byte[1:0];
    end
  end
`else
  logic unused_bits;

  assign led_out     = 2'b00;
  assign unused_bits = ^{sync_lvl, sync_rise[0], sync_fall[0]};
`endif

endmodule

// File: tb/tb_spi_joystick_responder.sv
// Bench for spi_joystick_responder: table of SPI frames driven by a bit-banged
// master, plus a reset check and a one-cycle ss pulse that closes in LOAD.
module tb_spi_joystick_responder;

`ifdef JSTK_RESP_LED_CMD_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif
  localparam logic [1:0] L11 = LED_EN ? 2'b11 : 2'b00;
  localparam logic [1:0] L10 = LED_EN ? 2'b10 : 2'b00;
  localparam logic [1:0] L01 = LED_EN ? 2'b01 : 2'b00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic [2:0] buttons = '0;
  logic [1:0] led_out;
  logic       xfer_done, frame_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  spi_joystick_responder #(.POS_W(10), .SCLK_SYNC(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .buttons   (buttons),
    .led_out   (led_out),
    .xfer_done (xfer_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Counts every cycle a pulse is high, so a stretched pulse shows up as >1.
  always @(negedge clk) begin
    if (xfer_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  typedef struct {
    int          nbits;
    int          half;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  btn;
    int          chg_bit;
    logic [9:0]  chg_x;
    int          rst_bit;
    logic [47:0] mosi_bits;
    logic [47:0] exp_miso;
    int          exp_done;
    int          exp_err;
    logic [1:0]  exp_led;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [47:0] actual,
                             input logic [47:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output logic [47:0] miso_bits,
                               output int lat);
    miso_bits = '0;
    lat = -1;
    x_pos = v.x;
    y_pos = v.y;
    buttons = v.btn;
    mosi = 1'b0;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b0;
    repeat (v.half) @(negedge clk);
    for (int i = 0; i < v.nbits; i++) begin
      if (i == v.chg_bit) x_pos = v.chg_x;
      if (i == v.rst_bit) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      mosi = v.mosi_bits[47-i];
      repeat (v.half) @(negedge clk);
      miso_bits[47-i] = miso;
      sclk = 1'b1;
      repeat (v.half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (v.half) @(negedge clk);
    ss = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if ((xfer_done || frame_err) && lat < 0) lat = k;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [47:0] got_miso, mask, all_ones;
    int lat, done_base, err_base;
    all_ones = '1;

    vecs[0] = '{40, 50, 10'h2A5, 10'h15A, 3'b101, -1, 10'h000, -1,
                48'h83_00_00_00_00_00, 48'hA5_02_5A_01_05_00, 1, 0, L11};
    vecs[1] = '{17, 10, 10'h1FF, 10'h000, 3'b000, -1, 10'h000, -1,
                48'h81_00_00_00_00_00, 48'hFF_01_00_00_00_00, 0, 1, L11};
    vecs[2] = '{48, 10, 10'h123, 10'h3C4, 3'b010, -1, 10'h000, -1,
                48'h80_00_00_00_00_00, 48'h23_01_C4_03_02_00, 0, 1, L11};
    vecs[3] = '{40, 10, 10'h3FF, 10'h3FF, 3'b111, -1, 10'h000, -1,
                48'h41_00_00_00_00_00, 48'hFF_03_FF_03_07_00, 1, 0, L11};
    vecs[4] = '{40, 10, 10'h0AB, 10'h254, 3'b001, -1, 10'h000, -1,
                48'h82_00_00_00_00_00, 48'hAB_00_54_02_01_00, 1, 0, L10};
    vecs[5] = '{40, 10, 10'h000, 10'h000, 3'b000, 4, 10'h3FF, -1,
                48'h00_00_00_00_00_00, 48'h00_00_00_00_00_00, 1, 0, L10};
    vecs[6] = '{40, 10, 10'h3FF, 10'h000, 3'b000, -1, 10'h000, -1,
                48'h81_00_00_00_00_00, 48'hFF_03_00_00_00_00, 1, 0, L01};
    vecs[7] = '{40, 10, 10'h055, 10'h2AA, 3'b011, -1, 10'h000, 20,
                48'h83_00_00_00_00_00, 48'h55_00_A0_00_00_00, 0, 0, 2'b00};
    vecs[8] = '{40, 10, 10'h2A5, 10'h15A, 3'b101, -1, 10'h000, -1,
                48'h83_00_00_00_00_00, 48'hA5_02_5A_01_05_00, 1, 0, L11};
    vecs[9] = '{0, 10, 10'h000, 10'h000, 3'b000, -1, 10'h000, -1,
                48'h0, 48'h0, 0, 1, L11};

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset miso", 48'(miso), 48'd0);
    checkOutput("reset led_out", 48'(led_out), 48'd0);
    checkOutput("reset xfer_done", 48'(xfer_done), 48'd0);
    checkOutput("reset frame_err", 48'(frame_err), 48'd0);

    for (int n = 0; n < 10; n++) begin
      done_base = done_cnt;
      err_base  = err_cnt;
      applyStimulus(vecs[n], got_miso, lat);
      mask = ~(all_ones >> vecs[n].nbits);
      if (vecs[n].nbits > 0)
        checkOutput($sformatf("vec%0d miso", n), got_miso & mask, vecs[n].exp_miso & mask);
      checkOutput($sformatf("vec%0d xfer_done count", n), 48'(done_cnt - done_base),
                  48'(vecs[n].exp_done));
      checkOutput($sformatf("vec%0d frame_err count", n), 48'(err_cnt - err_base),
                  48'(vecs[n].exp_err));
      checkOutput($sformatf("vec%0d led_out", n), 48'(led_out), 48'(vecs[n].exp_led));
      if (vecs[n].exp_done + vecs[n].exp_err > 0)
        checkOutput($sformatf("vec%0d pulse latency", n), 48'(lat), 48'd4);
    end

    // ss low for a single clk: the close lands while the FSM is still in LOAD.
    done_base = done_cnt;
    err_base  = err_cnt;
    @(negedge clk);
    ss = 1'b0;
    @(negedge clk);
    ss = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("load-close frame_err count", 48'(err_cnt - err_base), 48'd1);
    checkOutput("load-close xfer_done count", 48'(done_cnt - done_base), 48'd0);
    checkOutput("load-close led_out", 48'(led_out), 48'(L11));
    checkOutput("load-close miso", 48'(miso), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
